// File: rtl/idp_decoder_27_if.sv
// Bundles the codeword-side and data-side signals of the 27-bit IDP decoder.
// master drives codewords and controls; slave is the decoder.
`ifndef IBLEN27
`define IBLEN27 20
`endif

interface idp_decoder_27_if #(parameter int ERR_CNT_W = 16) ();
    logic                  in_valid;
    logic [26:0]           codein;
    logic                  hold;
    logic                  clr_err;
    logic                  out_valid;
    logic [`IBLEN27-1:0]   dataout;
    logic                  code_err;
    logic [ERR_CNT_W-1:0]  err_cnt;

    modport master (
        output in_valid, codein, hold, clr_err,
        input  out_valid, dataout, code_err, err_cnt
    );

    modport slave (
        input  in_valid, codein, hold, clr_err,
        output out_valid, dataout, code_err, err_cnt
    );
endinterface

// File: rtl/idp_decoder_27.sv
// Receive-side decoder for the 27-bit IDP crosstalk-avoidance code: 4-bit MSB
// group offset plus 23 Fibonacci digits, 3-stage pipeline with global hold.
`ifndef IBLEN27
`define IBLEN27 20
`endif

module idp_decoder_27 #(
    parameter int ERR_CNT_W = 16
) (
    input  logic            clock,
    input  logic            rst_n,
    idp_decoder_27_if.slave bus
);
    localparam int DW     = `IBLEN27;
    localparam int STAGES = 3;

    // FNS[k] is the weight of Fibonacci digit k+1: 1, 2, 3, 5, 8, ...
    function automatic logic [26:0][DW-1:0] fns_tab();
        logic [26:0][DW-1:0] t;
        t[0] = DW'(1);
        t[1] = DW'(2);
        for (int k = 2; k < 27; k++) t[k] = t[k-1] + t[k-2];
        return t;
    endfunction

    localparam logic [26:0][DW-1:0] FNS = fns_tab();

    typedef struct packed {
        logic [DW-1:0] off;
        logic [DW-1:0] lo_a;
        logic [DW-1:0] lo_b;
        logic          err;
    } s2_t;

    logic [STAGES:1]      vld_pipe;
    logic [26:0]          s1_code;
    s2_t                  s2_d, s2_q;
    logic [DW-1:0]        data_q;
    logic                 err_q;
    logic [ERR_CNT_W-1:0] cnt_q;

    always_comb begin
        s2_d = '0;
        unique case (s1_code[26:23])
            4'b0000: s2_d.off = '0;
            4'b0001: s2_d.off = FNS[23];
            4'b1000: s2_d.off = FNS[25];
            4'b1001: s2_d.off = FNS[23] + FNS[25];
            4'b0011: s2_d.off = FNS[23] + FNS[26];
            4'b1100: s2_d.off = FNS[25] + FNS[26];
            4'b0110: s2_d.off = FNS[26] + FNS[26];
            4'b0111: s2_d.off = FNS[26] + FNS[26] + FNS[23];
            4'b1110: s2_d.off = FNS[26] + FNS[26] + FNS[25];
            4'b1111: s2_d.off = FNS[26] + FNS[26] + FNS[25] + FNS[23];
            default: s2_d.err = 1'b1;
        endcase
        // Split the digit sum in two halves to shorten the S2 adder chain.
        for (int k = 0; k < 12; k++)
            if (s1_code[k]) s2_d.lo_a = s2_d.lo_a + FNS[k];
        for (int k = 12; k < 23; k++)
            if (s1_code[k]) s2_d.lo_b = s2_d.lo_b + FNS[k];
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s1_code  <= '0;
            s2_q     <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else if (!bus.hold) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], bus.in_valid};
            if (bus.in_valid) s1_code <= bus.codein;
            s2_q <= s2_d;
            if (vld_pipe[2]) begin
                data_q <= s2_q.err ? '0 : s2_q.off + s2_q.lo_a + s2_q.lo_b;
                err_q  <= s2_q.err;
            end
            // Clear takes priority over the count of the word landing this edge.
            if (bus.clr_err)
                cnt_q <= '0;
            else if (vld_pipe[2] && s2_q.err && cnt_q != '1)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.out_valid = vld_pipe[STAGES];
    assign bus.dataout   = data_q;
    assign bus.code_err  = err_q;
    assign bus.err_cnt   = cnt_q;
endmodule

// File: tb/tb_idp_decoder_27.sv
// Randomized bench for idp_decoder_27 against a Fibonacci-weight reference model
// with a due-edge scoreboard for latency, hold, bubbles, reset and err_cnt.
`ifndef IBLEN27
`define IBLEN27 20
`endif

module tb_idp_decoder_27;
    localparam int DW = `IBLEN27;
    localparam int CW = 8;
    localparam logic [CW-1:0] CMAX = '1;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    idp_decoder_27_if #(.ERR_CNT_W(CW)) bus ();
    idp_decoder_27 #(.ERR_CNT_W(CW)) dut (.clock(clock), .rst_n(rst_n), .bus(bus));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference: digit k (1-based) weighs fib[k]; fib[1]=1, fib[2]=2.
    int unsigned fib [1:27];
    logic [3:0] legal [10] = '{4'h0, 4'h1, 4'h8, 4'h9, 4'h3, 4'hC, 4'h6, 4'h7, 4'hE, 4'hF};

    function automatic void ref_dec(input logic [26:0] c, output int unsigned d, output bit e);
        int unsigned off;
        e = 0;
        off = 0;
        d = 0;
        for (int k = 0; k < 23; k++) if (c[k]) d += fib[k+1];
        case (c[26:23])
            4'h0: off = 0;
            4'h1: off = fib[24];
            4'h8: off = fib[26];
            4'h9: off = fib[24] + fib[26];
            4'h3: off = fib[24] + fib[27];
            4'hC: off = fib[26] + fib[27];
            4'h6: off = 2 * fib[27];
            4'h7: off = 2 * fib[27] + fib[24];
            4'hE: off = 2 * fib[27] + fib[26];
            4'hF: off = 2 * fib[27] + fib[26] + fib[24];
            default: e = 1;
        endcase
        d = e ? 0 : d + off;
    endfunction

    // Encoder model: largest legal offset not above d, then greedy Fibonacci digits.
    function automatic void enc(input int unsigned d, output logic [26:0] c, output bit ok);
        int unsigned best, off, rem;
        bit e;
        logic [3:0] bp;
        best = 0;
        bp = 4'h0;
        for (int i = 0; i < 10; i++) begin
            ref_dec({legal[i], 23'b0}, off, e);
            if (off <= d && off >= best) begin best = off; bp = legal[i]; end
        end
        rem = d - best;
        c = {bp, 23'b0};
        for (int k = 23; k >= 1; k--)
            if (fib[k] <= rem) begin c[k-1] = 1'b1; rem -= fib[k]; end
        ok = (rem == 0);
    endfunction

    // Scoreboard entries retire on a specific non-held edge number.
    typedef struct { int due; int unsigned d; bit e; } exp_t;
    exp_t q[$];
    int edge_n = 0;
    int unsigned nxt_ed = 0;
    bit nxt_ee = 0;
    logic [CW-1:0] exp_cnt = '0;
    bit last_v = 0;
    int unsigned last_d = 0;
    bit last_e = 0;

    bit s_rst, s_hold, s_v, s_clr, s_ee;
    int unsigned s_ed;

    always begin
        @(posedge clock);
        s_rst = rst_n; s_hold = bus.hold; s_v = bus.in_valid; s_clr = bus.clr_err;
        s_ed = nxt_ed; s_ee = nxt_ee;
        if (s_rst && !s_hold) begin
            edge_n++;
            if (s_v) q.push_back('{edge_n + 2, s_ed, s_ee});
        end
        @(negedge clock);
        if (!rst_n) begin
            q.delete();
            exp_cnt = '0; last_v = 0; last_d = 0; last_e = 0;
            chk("rst_valid", bus.out_valid, 0);
            chk("rst_data", bus.dataout, 0);
            chk("rst_err", bus.code_err, 0);
            chk("rst_cnt", bus.err_cnt, 0);
        end else if (!s_rst || s_hold) begin
            chk("frz_valid", bus.out_valid, last_v);
            chk("frz_data", bus.dataout, last_d);
            chk("frz_err", bus.code_err, last_e);
            chk("frz_cnt", bus.err_cnt, exp_cnt);
        end else begin
            bit ev, got_err;
            exp_t x;
            got_err = 0;
            ev = (q.size() > 0) && (q[0].due == edge_n);
            chk("out_valid", bus.out_valid, ev);
            if (ev) begin
                x = q.pop_front();
                last_d = x.d; last_e = x.e; got_err = x.e;
            end
            last_v = ev;
            chk("dataout", bus.dataout, last_d);
            chk("code_err", bus.code_err, last_e);
            if (s_clr) exp_cnt = '0;
            else if (got_err && exp_cnt != CMAX) exp_cnt = exp_cnt + 1'b1;
            chk("err_cnt", bus.err_cnt, exp_cnt);
        end
    end

    task automatic step(input bit v, input logic [26:0] c, input int unsigned ed, input bit ee,
                        input bit h, input bit clr);
        bus.in_valid = v; bus.codein = c; bus.hold = h; bus.clr_err = clr;
        nxt_ed = ed; nxt_ee = ee;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, $urandom, 0, 0, 0, 0);
    endtask

    task automatic send(input logic [26:0] c, input bit h, input bit clr);
        int unsigned d;
        bit e;
        ref_dec(c, d, e);
        step(1, c, d, e, h, clr);
    endtask

    initial begin
        int unsigned d;
        logic [26:0] c;
        bit ok;
        fib[1] = 1; fib[2] = 2;
        for (int k = 3; k <= 27; k++) fib[k] = fib[k-1] + fib[k-2];
        bus.in_valid = 0; bus.codein = '0; bus.hold = 0; bus.clr_err = 0;
        repeat (3) @(posedge clock);
        #1 rst_n = 1;

        // Single word, fixed latency
        send(27'h0000001, 0, 0);
        idle(2);
        chk("t1_valid", bus.out_valid, 1);
        chk("t1_data", bus.dataout, 1);
        idle(1);
        chk("t1_after", bus.out_valid, 0);
        idle(2);

        // All legal MSB groups back to back
        for (int i = 0; i < 10; i++) send({legal[i], 23'b0}, 0, 0);
        idle(4);

        // Illegal group, then saturation
        send({4'b0101, 23'($urandom) | 23'h1}, 0, 0);
        idle(3);
        chk("t3_err", bus.code_err, 1);
        chk("t3_data", bus.dataout, 0);
        chk("t3_cnt1", bus.err_cnt, 1);
        for (int i = 0; i < (1 << CW) + 2; i++) send({4'b0101, 23'($urandom) | 23'h1}, 0, 0);
        idle(4);
        chk("t3_sat", bus.err_cnt, CMAX);

        // Hold with three words in flight; inputs and clear during hold are ignored
        for (int i = 0; i < 3; i++) send({legal[i+3], 23'($urandom_range(0, 4000))}, 0, 0);
        for (int i = 0; i < 5; i++) step($urandom % 2, $urandom, 0, 0, 1, $urandom % 2);
        idle(5);

        // Clear coinciding with an errored word leaving S2
        step(0, 0, 0, 0, 0, 1);
        idle(2);
        chk("t5_clr", bus.err_cnt, 0);
        send({4'b1101, 23'h5}, 0, 0);
        idle(1);
        step(0, 0, 0, 0, 0, 1);
        chk("t5_clr_wins", bus.err_cnt, 0);
        send({4'b0010, 23'h9}, 0, 0);
        idle(3);
        chk("t5_cnt1", bus.err_cnt, 1);

        // Random codewords with random hold/clear
        for (int i = 0; i < 300; i++) begin
            if ($urandom % 4 != 0) send($urandom, ($urandom % 8) == 0, ($urandom % 16) == 0);
            else step(0, $urandom, 0, 0, ($urandom % 8) == 0, 0);
        end
        idle(5);

        // Round trip through the encoder model
        for (int i = 0; i < 200; i++) begin
            ok = 0;
            while (!ok) begin
                d = $urandom_range(0, 2 * fib[27] + fib[26] + fib[24] + fib[24] - 1);
                enc(d, c, ok);
            end
            step($urandom % 5 != 0, c, d, 0, ($urandom % 10) == 0, 0);
        end
        idle(5);

        // Reset mid-stream discards in-flight words
        for (int i = 0; i < 3; i++) send({legal[i], 23'($urandom_range(0, 1000))}, 0, 0);
        rst_n = 0;
        idle(2);
        rst_n = 1;
        idle(4);
        chk("rst_quiet", bus.out_valid, 0);
        send({4'h9, 23'h3}, 0, 0);
        idle(5);

        chk("drain", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
